tx_resp_arbiter: RTL and testbench

Arbiter that shares the async FIFO write port (REF_CLK domain) between the two response sources of the control path: 8-bit register-read data and 16-bit ALU results. It accepts one response at a time through a REQ/ACK handshake and serializes it into bytes. It writes those bytes to the FIFO with WINC, stalling on FIFO_FULL. Round-robin arbitration prevents back-to-back ALU traffic from starving register reads, and the reverse.

---
 rtl/tx_resp_arbiter.sv | 100 ++++++++++
 tb/tb_tx_resp_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter that serialises 8-bit register responses and 16-bit ALU
// results into bytes on the async FIFO write port, stalling on FIFO_FULL.
module tx_resp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REG_REQ,
    input  logic [DATA_WIDTH-1:0] REG_DATA,
    output logic                  REG_ACK,
    input  logic                  ALU_REQ,
    input  logic [ALU_WIDTH-1:0]  ALU_DATA,
    output logic                  ALU_ACK,
    input  logic                  FIFO_FULL,
    output logic                  WINC,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_REG,
        SEND_ALU_LO,
        SEND_ALU_HI
    } state_t;

    state_t                state_q, state_d;
    logic [ALU_WIDTH-1:0]  hold_q, hold_d;
    logic                  last_alu_q, last_alu_d;
    logic                  reg_ack_q, reg_ack_d;
    logic                  alu_ack_q, alu_ack_d;
    logic                  grant_reg, grant_alu;

    // On a tie the source that was not served last wins.
    assign grant_reg = REG_REQ & (~ALU_REQ | last_alu_q);
    assign grant_alu = ALU_REQ & ~grant_reg;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a variable unassigned (latch).
        state_d    = state_q;
        hold_d     = hold_q;
        last_alu_d = last_alu_q;
        reg_ack_d  = 1'b0;
        alu_ack_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_reg) begin
                    hold_d     = ALU_WIDTH'(REG_DATA);
                    reg_ack_d  = 1'b1;
                    last_alu_d = 1'b0;
                    state_d    = SEND_REG;
                end else if (grant_alu) begin
                    hold_d     = ALU_DATA;
                    alu_ack_d  = 1'b1;
                    last_alu_d = 1'b1;
                    state_d    = SEND_ALU_LO;
                end
            end
            SEND_REG:    if (!FIFO_FULL) state_d = IDLE;
            SEND_ALU_LO: if (!FIFO_FULL) state_d = SEND_ALU_HI;
            SEND_ALU_HI: if (!FIFO_FULL) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RST) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            last_alu_q <= 1'b1;
            reg_ack_q  <= 1'b0;
            alu_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_alu_q <= last_alu_d;
            reg_ack_q  <= reg_ack_d;
            alu_ack_q  <= alu_ack_d;
        end
    end

    assign REG_ACK = reg_ack_q;
    assign ALU_ACK = alu_ack_q;
    assign BUSY    = (state_q != IDLE);
    assign WINC    = (state_q != IDLE) & ~FIFO_FULL;

    always_comb begin
        WDATA = '0;
        unique case (state_q)
            SEND_REG, SEND_ALU_LO: WDATA = hold_q[DATA_WIDTH-1:0];
            SEND_ALU_HI:           WDATA = hold_q[ALU_WIDTH-1 -: DATA_WIDTH];
            default:               WDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Directed bench for tx_resp_arbiter: expected FIFO bytes are queued by the
// stimulus, and a negedge monitor pops and compares every WINC write.
module tb_tx_resp_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REG_REQ;
    logic [7:0]  REG_DATA;
    logic        REG_ACK;
    logic        ALU_REQ;
    logic [15:0] ALU_DATA;
    logic        ALU_ACK;
    logic        FIFO_FULL;
    logic        WINC;
    logic [7:0]  WDATA;
    logic        BUSY;

    int         n_compared = 0;
    int         n_mismatch = 0;
    logic [7:0] sb[$];

    tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REG_REQ   (REG_REQ),
        .REG_DATA  (REG_DATA),
        .REG_ACK   (REG_ACK),
        .ALU_REQ   (ALU_REQ),
        .ALU_DATA  (ALU_DATA),
        .ALU_ACK   (ALU_ACK),
        .FIFO_FULL (FIFO_FULL),
        .WINC      (WINC),
        .WDATA     (WDATA),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected byte.
    always @(negedge CLK) begin
        if (WINC === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_write", {24'h0, WDATA}, 32'hFFFF_FFFF);
            end else begin
                check("wdata", {24'h0, WDATA}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits for the selected ACK; n is the number of edges taken (40 = timeout).
    task automatic wait_ack(input bit is_alu, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(is_alu ? ALU_ACK : REG_ACK) && n < 40);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(name, sb.size(), 0);
    endtask

    task automatic reg_requester(input logic [7:0] d, input int times);
        int n;
        for (int k = 0; k < times; k++) begin
            REG_REQ  = 1'b1;
            REG_DATA = d;
            wait_ack(1'b0, n);
            if (!REG_ACK) check("alt_reg_ack_timeout", {31'h0, REG_ACK}, 1);
        end
        REG_REQ = 1'b0;
    endtask

    task automatic alu_requester(input logic [15:0] d, input int times);
        int n;
        for (int k = 0; k < times; k++) begin
            ALU_REQ  = 1'b1;
            ALU_DATA = d;
            wait_ack(1'b1, n);
            if (!ALU_ACK) check("alt_alu_ack_timeout", {31'h0, ALU_ACK}, 1);
        end
        ALU_REQ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST = 1'b0; REG_REQ = 1'b0; REG_DATA = '0;
        ALU_REQ = 1'b0; ALU_DATA = '0; FIFO_FULL = 1'b0;
        #3;
        check("rst_busy",    {31'h0, BUSY},    0);
        check("rst_winc",    {31'h0, WINC},    0);
        check("rst_wdata",   {24'h0, WDATA},   0);
        check("rst_reg_ack", {31'h0, REG_ACK}, 0);
        check("rst_alu_ack", {31'h0, ALU_ACK}, 0);
        tick(); tick();
        RST = 1'b1;
        tick();

        // Reset asserted mid SEND_ALU_HI: LO byte 0xBC goes out, HI byte is lost.
        sb.push_back(8'hBC);
        ALU_REQ = 1'b1; ALU_DATA = 16'h9ABC;
        wait_ack(1'b1, n);
        check("midrst_ack_latency", n, 1);
        ALU_REQ = 1'b0;
        tick();
        check("midrst_busy_hi", {31'h0, BUSY}, 1);
        RST = 1'b0;
        #1;
        check("midrst_winc",    {31'h0, WINC},    0);
        check("midrst_busy",    {31'h0, BUSY},    0);
        check("midrst_alu_ack", {31'h0, ALU_ACK}, 0);
        check("midrst_wdata",   {24'h0, WDATA},   0);
        tick(); tick();
        RST = 1'b1;
        repeat (4) tick();
        check("midrst_idle_after", {31'h0, BUSY}, 0);
        check("midrst_sb_empty", sb.size(), 0);

        // Single register read.
        sb.push_back(8'hA5);
        REG_REQ = 1'b1; REG_DATA = 8'hA5;
        wait_ack(1'b0, n);
        check("reg_ack_latency", n, 1);
        check("reg_busy", {31'h0, BUSY}, 1);
        REG_REQ = 1'b0;
        tick();
        check("reg_ack_pulse_end", {31'h0, REG_ACK}, 0);
        check("reg_busy_one_cycle", {31'h0, BUSY}, 0);
        drain("reg_drain");

        // Single ALU result, LSB first.
        sb.push_back(8'h34); sb.push_back(8'h12);
        ALU_REQ = 1'b1; ALU_DATA = 16'h1234;
        wait_ack(1'b1, n);
        check("alu_ack_latency", n, 1);
        ALU_REQ = 1'b0;
        tick();
        check("alu_ack_pulse_end", {31'h0, ALU_ACK}, 0);
        check("alu_busy_hi", {31'h0, BUSY}, 1);
        tick();
        check("alu_busy_done", {31'h0, BUSY}, 0);
        drain("alu_drain");

        // Fresh reset so the first tie goes to REG, then strict alternation.
        RST = 1'b0; tick(); RST = 1'b1; tick();
        sb.push_back(8'h11); sb.push_back(8'hEF); sb.push_back(8'hBE);
        sb.push_back(8'h11); sb.push_back(8'hEF); sb.push_back(8'hBE);
        fork
            reg_requester(8'h11, 2);
            alu_requester(16'hBEEF, 2);
        join
        drain("alt_drain");

        // Backpressure between LO and HI bytes.
        sb.push_back(8'hFE); sb.push_back(8'hCA);
        ALU_REQ = 1'b1; ALU_DATA = 16'hCAFE;
        wait_ack(1'b1, n);
        check("bp_ack_latency", n, 1);
        ALU_REQ = 1'b0;
        tick();
        FIFO_FULL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_winc_stall", {31'h0, WINC}, 0);
            check("bp_wdata_held", {24'h0, WDATA}, 32'hCA);
            tick();
        end
        FIFO_FULL = 1'b0;
        #1;
        check("bp_winc_release", {31'h0, WINC}, 1);
        tick();
        check("bp_idle", {31'h0, BUSY}, 0);
        drain("bp_drain");

        // REG request raised during SEND_ALU_LO waits for the HI byte.
        sb.push_back(8'h78); sb.push_back(8'h56); sb.push_back(8'h3C);
        ALU_REQ = 1'b1; ALU_DATA = 16'h5678;
        wait_ack(1'b1, n);
        check("late_alu_ack_latency", n, 1);
        ALU_REQ = 1'b0;
        REG_REQ = 1'b1; REG_DATA = 8'h3C;
        wait_ack(1'b0, n);
        check("late_reg_ack_latency", n, 3);
        REG_REQ = 1'b0;
        drain("late_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
